// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one multiply or divide at a time through the external
// multi-cycle units and owns the architectural HI/LO registers. Handles
// divide-by-zero rejection, a watchdog on hung units, and mthi/mtlo writes.
module muldiv_ctrl #(
    parameter int W       = 32,
    parameter int TIMEOUT = 40
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         op_valid,
    input  logic         op_sel,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         op_ready,
    output logic         stall,
    output logic         mul_start,
    output logic         div_start,
    output logic [W-1:0] unit_a,
    output logic [W-1:0] unit_b,
    input  logic         mul_busy,
    input  logic         div_busy,
    input  logic [W-1:0] mul_hi,
    input  logic [W-1:0] mul_lo,
    input  logic [W-1:0] div_hi,
    input  logic [W-1:0] div_lo,
    input  logic         wr_hi,
    input  logic         wr_lo,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         done,
    output logic         div_zero,
    output logic         err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    state_t        state;
    logic          sel;
    logic [CW-1:0] wdog;
    logic          sel_busy;

    // Only the unit that was launched is watched; the other may be doing anything.
    assign sel_busy = sel ? div_busy : mul_busy;
    assign op_ready = (state == IDLE);
    assign stall    = (state != IDLE);

    // Sequencer: accept, launch pulse, wait for busy to drop or the watchdog to expire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sel       <= 1'b0;
            wdog      <= '0;
            unit_a    <= '0;
            unit_b    <= '0;
            hi        <= '0;
            lo        <= '0;
            mul_start <= 1'b0;
            div_start <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            err       <= 1'b0;
        end else begin
            // Status and launch signals are single-cycle pulses by default.
            mul_start <= 1'b0;
            div_start <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    // Direct writes land now; a same-edge op overwrites them at commit.
                    if (wr_hi) hi <= wr_data;
                    if (wr_lo) lo <= wr_data;
                    if (op_valid) begin
                        if (op_sel && (op_b == '0)) begin
                            div_zero <= 1'b1;
                        end else begin
                            sel       <= op_sel;
                            unit_a    <= op_a;
                            unit_b    <= op_b;
                            // Registered here so the pulse lines up with the LAUNCH cycle.
                            mul_start <= ~op_sel;
                            div_start <= op_sel;
                            state     <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A falling busy wins over a watchdog expiring on the same edge.
                    if (!sel_busy) begin
                        hi    <= sel ? div_hi : mul_hi;
                        lo    <= sel ? div_lo : mul_lo;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (wdog == CW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wdog <= wdog + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural multiply/divide unit stand-ins, a
// table of fixed vectors, hand-written corner sequences, and a randomized
// phase checked against a transaction-level HI/LO model.
module tb_muldiv_ctrl;

    localparam int W       = 32;
    localparam int TIMEOUT = 40;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         op_valid = 1'b0, op_sel = 1'b0;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic         op_ready, stall, mul_start, div_start;
    logic [W-1:0] unit_a, unit_b;
    logic         mul_busy, div_busy;
    logic [W-1:0] mul_hi, mul_lo, div_hi, div_lo;
    logic         wr_hi = 1'b0, wr_lo = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic [W-1:0] hi, lo;
    logic         done, div_zero, err;

    int checks = 0;
    int errors = 0;

    muldiv_ctrl #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_sel(op_sel), .op_a(op_a), .op_b(op_b),
        .op_ready(op_ready), .stall(stall),
        .mul_start(mul_start), .div_start(div_start),
        .unit_a(unit_a), .unit_b(unit_b),
        .mul_busy(mul_busy), .div_busy(div_busy),
        .mul_hi(mul_hi), .mul_lo(mul_lo), .div_hi(div_hi), .div_lo(div_lo),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .hi(hi), .lo(lo),
        .done(done), .div_zero(div_zero), .err(err)
    );

    always #5 clk = ~clk;

    // Unit stand-ins: 32-cycle signed multiplier, unsigned divider with adjustable latency.
    int          mcnt, dcnt;
    int          div_lat = 10;
    logic        mul_stuck = 1'b0;
    logic [63:0] mprod;
    logic [W-1:0] dq, dr;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcnt <= 0;
            dcnt <= 0;
        end else begin
            if (mul_start) begin
                mcnt  <= 32;
                mprod <= longint'($signed(unit_a)) * longint'($signed(unit_b));
            end else if (mcnt > 0) begin
                mcnt <= mcnt - 1;
            end
            if (div_start) begin
                dcnt <= div_lat;
                dq   <= unit_a / unit_b;
                dr   <= unit_a % unit_b;
            end else if (dcnt > 0) begin
                dcnt <= dcnt - 1;
            end
        end
    end

    assign mul_busy = (mcnt != 0) || mul_stuck;
    assign div_busy = (dcnt != 0);
    assign mul_hi   = mprod[63:32];
    assign mul_lo   = mprod[31:0];
    assign div_hi   = dr;
    assign div_lo   = dq;

    // Reference HI/LO as seen by software
    logic [W-1:0] m_hi = '0, m_lo = '0;

    function automatic logic [63:0] ref_result(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        if (s) return {a % b, a / b};
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_direct(input logic h, input logic l, input logic [W-1:0] d);
        wr_hi = h; wr_lo = l; wr_data = d;
        step();
        wr_hi = 1'b0; wr_lo = 1'b0;
        if (h) m_hi = d;
        if (l) m_lo = d;
    endtask

    // Issue one op from IDLE and follow it to its status pulse; returns in that pulse cycle.
    task automatic do_op(input string nm, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic wh, input logic wl, input logic [W-1:0] wd, input logic ww,
                         input int ekind, input int elat);
        int   nmul, ndiv, kind, lat;
        logic bad_start, bad_stall, bad_opnd, bad_excl;
        logic dz;
        logic [63:0] hl_before;
        dz = s && (b == '0);
        nmul = 0; ndiv = 0; kind = -1; lat = 0;
        bad_start = 0; bad_stall = 0; bad_opnd = 0; bad_excl = 0;
        hl_before = '0;
        op_valid = 1'b1; op_sel = s; op_a = a; op_b = b;
        wr_hi = wh; wr_lo = wl; wr_data = wd;
        step();
        op_valid = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        op_a = $urandom; op_b = $urandom;
        if (wh) chk({nm, "_accept_wr_hi"}, hi, wd);
        if (wl) chk({nm, "_accept_wr_lo"}, lo, wd);
        for (int c = 1; c <= 100; c++) begin
            if (mul_start) begin nmul++; if (c != 1) bad_start = 1; end
            if (div_start) begin ndiv++; if (c != 1) bad_start = 1; end
            if (mul_start && div_start) bad_start = 1;
            if (!$onehot0({done, div_zero, err})) bad_excl = 1;
            if (ww && c == 6) chk({nm, "_wait_wr_ignored"}, {hi, lo}, hl_before);
            if (done || div_zero || err) begin
                kind = done ? 0 : (div_zero ? 1 : 2);
                lat  = c;
                if (stall || !op_ready) bad_stall = 1;
                break;
            end
            if (!stall || op_ready) bad_stall = 1;
            if (unit_a !== a || unit_b !== b) bad_opnd = 1;
            if (ww && c == 5) begin
                hl_before = {hi, lo};
                wr_hi = 1'b1; wr_lo = 1'b1; wr_data = ~wd;
            end else begin
                wr_hi = 1'b0; wr_lo = 1'b0;
            end
            step();
        end
        wr_hi = 1'b0; wr_lo = 1'b0;
        chk({nm, "_kind"}, kind, ekind);
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_mul_starts"}, nmul, (!dz && !s) ? 1 : 0);
        chk({nm, "_div_starts"}, ndiv, (!dz && s) ? 1 : 0);
        chk({nm, "_start_timing"}, bad_start, 0);
        chk({nm, "_stall_ready"}, bad_stall, 0);
        chk({nm, "_pulse_excl"}, bad_excl, 0);
        if (!dz) chk({nm, "_operands_held"}, bad_opnd, 0);
    endtask

    // Op plus reference-model update and HI/LO comparison.
    task automatic run(input string nm, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic wh, input logic wl, input logic [W-1:0] wd, input logic ww,
                       input int ekind, input int elat);
        if (wh) m_hi = wd;
        if (wl) m_lo = wd;
        do_op(nm, s, a, b, wh, wl, wd, ww, ekind, elat);
        if (ekind == 0) {m_hi, m_lo} = ref_result(s, a, b);
        chk({nm, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    endtask

    typedef struct {
        logic         s;
        logic [W-1:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
        int           dlat, kind, lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL global_timeout: got hung expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int   nbad;
        logic s, wh, wl;
        logic [W-1:0] a, b, d;
        int   r;

        vecs[0] = '{1'b0, 32'h7, 32'hFFFFFFFD, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFEB, 10, 0, 35};
        vecs[1] = '{1'b1, 32'd100, 32'd7, 32'h0, 32'h0, 32'd2, 32'd14, 10, 0, 13};
        vecs[2] = '{1'b1, 32'd5, 32'd0, 32'hA, 32'hB, 32'hA, 32'hB, 10, 1, 1};
        vecs[3] = '{1'b0, 32'h80000000, 32'h80000000, 32'h1, 32'h2, 32'h40000000, 32'h0, 10, 0, 35};
        vecs[4] = '{1'b1, 32'hFFFFFFFF, 32'd1, 32'h3, 32'h4, 32'h0, 32'hFFFFFFFF, 1, 0, 4};
        vecs[5] = '{1'b1, 32'd9, 32'd4, 32'h0, 32'h0, 32'd1, 32'd2, 1, 0, 4};
        vecs[6] = '{1'b1, 32'd1000, 32'd10, 32'h0, 32'h0, 32'd0, 32'd100, 39, 0, 42};
        vecs[7] = '{1'b1, 32'd1000, 32'd10, 32'h5, 32'h6, 32'h5, 32'h6, 40, 2, 42};

        // Reset state
        #1;
        chk("rst_hilo", {hi, lo}, 64'h0);
        chk("rst_ready_stall", {op_ready, stall}, 2'b10);
        chk("rst_pulses", {done, div_zero, err, mul_start, div_start}, 5'b0);
        chk("rst_units", {unit_a, unit_b}, 64'h0);
        step(); step();
        reset = 1'b1;
        step();

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            wr_direct(1'b1, 1'b0, vecs[i].pre_hi);
            wr_direct(1'b0, 1'b1, vecs[i].pre_lo);
            div_lat = vecs[i].dlat;
            run($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, 1'b0, 1'b0, '0, 1'b0,
                vecs[i].kind, vecs[i].lat);
            chk($sformatf("vec%0d_table_hilo", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
            step();
            chk($sformatf("vec%0d_pulse_once", i), {done, div_zero, err}, 3'b0);
        end

        // mthi together with a mult accept, then back-to-back mult at the commit+1 edge
        run("wr_with_mult", 1'b0, 32'd2, 32'd3, 1'b1, 1'b0, 32'h1234, 1'b0, 0, 35);
        chk("wr_with_mult_result", {hi, lo}, {32'h0, 32'h6});
        run("back2back", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, '0, 1'b0, 0, 35);

        // div-by-zero followed immediately by an accept at E1
        wr_direct(1'b1, 1'b1, 32'h55);
        run("dz_b2b", 1'b1, 32'd5, 32'd0, 1'b0, 1'b0, '0, 1'b0, 1, 1);
        div_lat = 5;
        run("after_dz", 1'b1, 32'd50, 32'd6, 1'b0, 1'b0, '0, 1'b0, 0, 8);

        // Hung multiplier with writes attempted during WAIT
        wr_direct(1'b1, 1'b1, 32'hCAFE);
        mul_stuck = 1'b1;
        run("timeout", 1'b0, 32'd3, 32'd4, 1'b0, 1'b0, 32'h77, 1'b1, 2, TIMEOUT + 2);
        mul_stuck = 1'b0;
        step();
        chk("timeout_err_once", {err, op_ready, stall}, 3'b010);

        // Asynchronous reset in the middle of WAIT
        op_valid = 1'b1; op_sel = 1'b0; op_a = 32'd5; op_b = 32'd5;
        step();
        op_valid = 1'b0;
        repeat (9) step();
        reset = 1'b0;
        #1;
        chk("midrst_hilo", {hi, lo}, 64'h0);
        chk("midrst_ready_stall", {op_ready, stall}, 2'b10);
        m_hi = '0; m_lo = '0;
        step();
        reset = 1'b1;
        nbad = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (done || err || div_zero || mul_start || div_start || stall) nbad++;
        end
        chk("midrst_quiet", nbad, 0);
        run("after_rst", 1'b0, 32'd6, 32'd7, 1'b0, 1'b0, '0, 1'b0, 0, 35);

        // Randomized mix against the reference model
        for (int i = 0; i < 60; i++) begin
            r  = $urandom_range(3);
            a  = $urandom;
            b  = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
            d  = $urandom;
            wh = ($urandom_range(3) == 0);
            wl = ($urandom_range(3) == 0);
            if (r == 0) begin
                wr_direct(wh, wl, d);
                chk($sformatf("rnd%0d_wr", i), {hi, lo}, {m_hi, m_lo});
            end else if (r == 1) begin
                run($sformatf("rnd%0d_mul", i), 1'b0, a, b, wh, wl, d, 1'b0, 0, 35);
            end else begin
                div_lat = $urandom_range(39, 1);
                s = 1'b1;
                run($sformatf("rnd%0d_div", i), s, a, b, wh, wl, d, 1'b0,
                    (b == 0) ? 1 : 0, (b == 0) ? 1 : div_lat + 3);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
